bf16_cmd_sequencer: RTL and testbench
=====================================

Name: bf16_cmd_sequencer

Overview:
Command decoder and sequencer between the SPI slave word interface and the bfloat16 arithmetic unit inside bfloat16_spi_top. It consumes each completed 16-bit MOSI word and interprets it as an opcode or an operand. It drives the ALU with a start/done handshake and owns the bfloat16 accumulator. It returns each result word to the SPI shifter, which shifts it out on MISO during the next frame.

Parameters:
W, 16, data/word width (bfloat16)
TIMEOUT, 64, max cycles to wait for alu_done before aborting
END_WORD, 16'hFFFF, stream terminator / dummy read word

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low (asserted when 0)
rx_word  in  W  word received from SPI (LSB-first already reassembled)
rx_valid  in  1  1-cycle pulse, rx_word valid
tx_word  out  W  word to load into SPI shift-out register
tx_load  out  1  1-cycle pulse, tx_word valid
alu_op  out  2  0=ADD 1=SUB 2=MUL 3=DIV
alu_a  out  W  operand A
alu_b  out  W  operand B
alu_start  out  1  1-cycle start pulse
alu_done  in  1  1-cycle completion pulse
alu_result  in  W  result, valid with alu_done
busy  out  1  high in any state other than IDLE/STREAM_WAIT/SET_WAIT/GET_A/GET_B
err  out  1  sticky: overrun, timeout or illegal opcode; cleared by reset or opcode 0x0000

Behaviour:
- Reset (rst=0 at posedge) values: state=IDLE; acc=0; tx_word=0; tx_load=0; alu_start=0; alu_op=0; alu_a=alu_b=0; busy=0; err=0. Reset mid-operation aborts immediately. A late alu_done after reset is ignored.
- Opcodes are accepted in IDLE only:
  - 0x0000 ZERO: acc<=0 and err<=0.
  - 0x0001 SET_ACC: go to SET_WAIT. The next word loads acc, then return to IDLE.
  - 0x0002 LOAD_ACC: tx_word<=acc and tx_load=1 on the next cycle. Stay in IDLE.
  - 0x0003 ADD, 0x0004 SUB, 0x0005 MUL, 0x0006 DIV: latch alu_op = opcode-3, then GET_A -> GET_B -> EXEC.
  - 0x0007 SUM, 0x0008 SUB-stream: acc<=0, latch op (ADD / SUB), go to STREAM_WAIT.
  - END_WORD in IDLE: ignored, no error (dummy read frame).
  - Any other value: err<=1, stay in IDLE.
- GET_A / GET_B: the next rx_valid latches alu_a / alu_b. After GET_B, alu_start pulses exactly one cycle later, then EXEC.
- EXEC: wait for alu_done. On done: tx_word<=alu_result, tx_load pulse on the following cycle, return to IDLE. acc is unchanged by binary ops.
- STREAM_WAIT:
  - A word != END_WORD: alu_a=acc, alu_b=word, alu_start pulse, go to STREAM_EXEC.
  - On done: acc<=alu_result, return to STREAM_WAIT.
  - END_WORD: return to IDLE with no tx_load. The result is read via 0x0002.
  - Stream order for SUB: acc = acc - word, so 0 - 1 - 2 - 3 = -6.
- Latency: rx_valid of the final operand -> alu_start is 1 cycle. alu_done -> tx_load is 1 cycle.
- Overrun: an rx_valid while in EXEC or STREAM_EXEC drops the word and sets err<=1. The state machine continues.
- Timeout: a cycle counter runs in EXEC/STREAM_EXEC. After TIMEOUT cycles without alu_done: err<=1, return to IDLE, no tx_load, acc unchanged.
- Simultaneous alu_done and rx_valid in an EXEC state: done is processed and the word is dropped as overrun.
- No arithmetic is performed in this block. Word width is fixed at W. No special handling of NaN/Inf; END_WORD (a NaN pattern) is always treated as the terminator.

Decomposition:
- Shared package bf16_pkg: opcode constants (OP_ZERO..OP_SUBS, END_WORD), the alu_op encoding, and the state enum.
- One natural sub-module: bf16_timeout_ctr (load/clear/expire counter, width clog2(TIMEOUT+1)).
- The FSM and accumulator stay in the top of this block.

Test Plan:
- MUL: 0005, 4148, 404d -> alu_op=2, alu_a=4148, alu_b=404d; ALU model returns 4220 -> tx_word=4220 with one tx_load.
- SUB binary: 0004, 4237, 441c, FFFF -> alu_op=1; tx_word=c411; the trailing FFFF is ignored and err stays 0.
- SUM stream: 0007, 3f80, 4000, 4040, 3f80, FFFF, 0002 -> 4 alu_start pulses with op=ADD; tx_word=40E0.
- SUB stream: 0008, 3f80, 4000, 4040, FFFF, 0002 -> tx_word=c0c0. Also SET_ACC path: 0001, bbbb, 0002 -> tx_word=bbbb; then 0000, 0002 -> tx_word=0000.
- Faults: 0009 -> err=1. Word sent during EXEC -> err=1, word dropped. alu_done withheld 64 cycles -> err=1, state returns to IDLE. 0000 -> err=0.
- Reset mid-EXEC: rst=0 for 1 cycle -> all outputs at reset values and acc=0; a subsequent alu_done pulse produces no tx_load.

Source files
------------

// File: rtl/bf16_pkg.sv
// ============================================================================
// Module      : bf16_pkg
// Description : Shared constants and types for the bfloat16 command sequencer:
//               opcode values, stream terminator, ALU operation encoding and
//               the sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bf16_pkg;

  // Command opcodes, accepted only while the sequencer is idle
  localparam logic [15:0] OP_ZERO     = 16'h0000;
  localparam logic [15:0] OP_SET_ACC  = 16'h0001;
  localparam logic [15:0] OP_LOAD_ACC = 16'h0002;
  localparam logic [15:0] OP_ADD      = 16'h0003;
  localparam logic [15:0] OP_SUB      = 16'h0004;
  localparam logic [15:0] OP_MUL      = 16'h0005;
  localparam logic [15:0] OP_DIV      = 16'h0006;
  localparam logic [15:0] OP_SUM      = 16'h0007;
  localparam logic [15:0] OP_SUBS     = 16'h0008;

  // Stream terminator and dummy-read word (a NaN pattern, never an operand)
  localparam logic [15:0] END_WORD    = 16'hFFFF;

  // alu_op encoding
  localparam logic [1:0]  ALU_ADD     = 2'd0;
  localparam logic [1:0]  ALU_SUB     = 2'd1;
  localparam logic [1:0]  ALU_MUL     = 2'd2;
  localparam logic [1:0]  ALU_DIV     = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_SET_WAIT    = 3'd1,
    ST_GET_A       = 3'd2,
    ST_GET_B       = 3'd3,
    ST_EXEC        = 3'd4,
    ST_STREAM_WAIT = 3'd5,
    ST_STREAM_EXEC = 3'd6
  } state_t;

  // Binary opcodes 3..6 map linearly onto ALU ops 0..3
  function automatic logic [1:0] bin_alu_op(input logic [15:0] opcode);
    logic [15:0] v_diff;
    v_diff = opcode - OP_ADD;
    return v_diff[1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/bf16_cmd_sequencer_if.sv
// ============================================================================
// Module      : bf16_cmd_sequencer_if
// Description : Bundle of the SPI word side and ALU side of the sequencer.
//   master : sequencer view  (drives tx_*, alu_op/a/b/start, busy, err)
//   slave  : environment view (drives rx_*, alu_done, alu_result)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bf16_cmd_sequencer_if #(
  parameter int W = 16
);
  logic [W-1:0] rx_word;
  logic         rx_valid;
  logic [W-1:0] tx_word;
  logic         tx_load;
  logic [1:0]   alu_op;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic         alu_start;
  logic         alu_done;
  logic [W-1:0] alu_result;
  logic         busy;
  logic         err;

  modport master (
    input  rx_word, rx_valid, alu_done, alu_result,
    output tx_word, tx_load, alu_op, alu_a, alu_b, alu_start, busy, err
  );

  modport slave (
    output rx_word, rx_valid, alu_done, alu_result,
    input  tx_word, tx_load, alu_op, alu_a, alu_b, alu_start, busy, err
  );
endinterface

`default_nettype wire

// File: rtl/bf16_timeout_ctr.sv
// ============================================================================
// Module      : bf16_timeout_ctr
// Description : Down-counter guarding the wait for alu_done.
//   clk, rst  : clock, synchronous active-low reset
//   i_load    : arm the counter (coincides with alu_start)
//   i_clr     : clear the counter
//   i_run     : high while waiting for alu_done; counts down
//   o_expire  : high during the TIMEOUT-th waiting cycle
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bf16_timeout_ctr #(
  parameter int TIMEOUT = 64
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_load,
  input  wire logic i_clr,
  input  wire logic i_run,
  output logic      o_expire
);
  localparam int          CW       = $clog2(TIMEOUT + 1);
  // Loaded with TIMEOUT-1 so the count reaches zero on the TIMEOUT-th cycle
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_run && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_expire = i_run && (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/bf16_cmd_sequencer.sv
// ============================================================================
// Module      : bf16_cmd_sequencer
// Description : Decodes SPI words into opcodes/operands, sequences the
//               bfloat16 ALU through a start/done handshake, owns the
//               accumulator and returns result words to the SPI shifter.
//   clk, rst  : clock, synchronous active-low reset
//   io_bus    : master modport (rx word in, tx word out, ALU handshake,
//               busy and sticky err flags)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bf16_cmd_sequencer
  import bf16_pkg::*;
#(
  parameter int          W        = 16,
  parameter int          TIMEOUT  = 64,
  parameter logic [W-1:0] END_WORD = 16'hFFFF
) (
  input  wire logic             clk,
  input  wire logic             rst,
  bf16_cmd_sequencer_if.master  io_bus
);

  state_t       r_state;
  state_t       w_next;
  logic [W-1:0] r_acc;
  logic [W-1:0] r_tx_word;
  logic         r_tx_load;
  logic [1:0]   r_alu_op;
  logic [W-1:0] r_alu_a;
  logic [W-1:0] r_alu_b;
  logic         r_alu_start;
  logic         r_err;

  logic         w_rx;
  logic [W-1:0] w_word;
  logic         w_in_exec;
  logic         w_busy;
  logic         w_done;
  logic         w_overrun;
  logic         w_expire;
  logic         w_timeout;
  logic         w_illegal;
  logic         w_start;
  logic         w_is_bin;

  assign w_rx     = io_bus.rx_valid;
  assign w_word   = io_bus.rx_word;
  assign w_is_bin = (w_word >= OP_ADD) && (w_word <= OP_DIV);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_rx) begin
          if (w_word == OP_SET_ACC)                         w_next = ST_SET_WAIT;
          else if (w_is_bin)                                w_next = ST_GET_A;
          else if ((w_word == OP_SUM) || (w_word == OP_SUBS)) w_next = ST_STREAM_WAIT;
        end
      end
      ST_SET_WAIT: if (w_rx) w_next = ST_IDLE;
      ST_GET_A:    if (w_rx) w_next = ST_GET_B;
      ST_GET_B:    if (w_rx) w_next = ST_EXEC;
      ST_EXEC: begin
        if (w_done || w_expire) w_next = ST_IDLE;
      end
      ST_STREAM_WAIT: begin
        if (w_rx) w_next = (w_word == END_WORD) ? ST_IDLE : ST_STREAM_EXEC;
      end
      ST_STREAM_EXEC: begin
        if (w_done)        w_next = ST_STREAM_WAIT;
        else if (w_expire) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output / event decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_in_exec = (r_state == ST_EXEC) || (r_state == ST_STREAM_EXEC);
    w_busy    = w_in_exec;
    w_done    = w_in_exec && io_bus.alu_done;
    // A word arriving alongside alu_done is still dropped as an overrun
    w_overrun = w_in_exec && w_rx;
    w_timeout = w_expire && !io_bus.alu_done;
    w_illegal = (r_state == ST_IDLE) && w_rx &&
                (w_word > OP_SUBS) && (w_word != END_WORD);
    w_start   = w_rx && ((r_state == ST_GET_B) ||
                         ((r_state == ST_STREAM_WAIT) && (w_word != END_WORD)));
  end

  bf16_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_start),
    .i_clr    (!w_in_exec),
    .i_run    (w_in_exec),
    .o_expire (w_expire)
  );

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_acc       <= '0;
      r_tx_word   <= '0;
      r_tx_load   <= 1'b0;
      r_alu_op    <= ALU_ADD;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_start <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_alu_start <= w_start;
      r_tx_load   <= 1'b0;
      if (w_overrun || w_timeout || w_illegal) r_err <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (w_rx) begin
            if (w_word == OP_ZERO) begin
              r_acc <= '0;
              r_err <= 1'b0;
            end else if (w_word == OP_LOAD_ACC) begin
              r_tx_word <= r_acc;
              r_tx_load <= 1'b1;
            end else if (w_is_bin) begin
              r_alu_op <= bin_alu_op(w_word);
            end else if (w_word == OP_SUM) begin
              r_acc    <= '0;
              r_alu_op <= ALU_ADD;
            end else if (w_word == OP_SUBS) begin
              r_acc    <= '0;
              r_alu_op <= ALU_SUB;
            end
          end
        end
        ST_SET_WAIT: if (w_rx) r_acc   <= w_word;
        ST_GET_A:    if (w_rx) r_alu_a <= w_word;
        ST_GET_B:    if (w_rx) r_alu_b <= w_word;
        ST_EXEC: begin
          if (w_done) begin
            r_tx_word <= io_bus.alu_result;
            r_tx_load <= 1'b1;
          end
        end
        ST_STREAM_WAIT: begin
          if (w_rx && (w_word != END_WORD)) begin
            r_alu_a <= r_acc;
            r_alu_b <= w_word;
          end
        end
        ST_STREAM_EXEC: if (w_done) r_acc <= io_bus.alu_result;
        default: ;
      endcase
    end
  end

  assign io_bus.tx_word   = r_tx_word;
  assign io_bus.tx_load   = r_tx_load;
  assign io_bus.alu_op    = r_alu_op;
  assign io_bus.alu_a     = r_alu_a;
  assign io_bus.alu_b     = r_alu_b;
  assign io_bus.alu_start = r_alu_start;
  assign io_bus.busy      = w_busy;
  assign io_bus.err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_bf16_cmd_sequencer.sv
// ============================================================================
// Module      : tb_bf16_cmd_sequencer
// Description : Directed self-checking bench for bf16_cmd_sequencer with an
//               ALU responder model and a tx_word scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bf16_cmd_sequencer;
  import bf16_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bf16_cmd_sequencer_if #(.W(16)) bus();

  bf16_cmd_sequencer #(
    .W(16), .TIMEOUT(64), .END_WORD(16'hFFFF)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic        bin;
  } alu_exp_t;

  alu_exp_t    aluq[$];
  logic [15:0] txq[$];
  int          checks    = 0;
  int          errors    = 0;
  int          start_cnt = 0;
  bit          alu_auto  = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_alu(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] r, input logic bin);
    alu_exp_t e;
    e.op = op; e.a = a; e.b = b; e.r = r; e.bin = bin;
    aluq.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("wait_idle_timeout", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic send_raw(input logic [15:0] w);
    @(negedge clk);
    bus.rx_word  = w;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send(input logic [15:0] w);
    wait_idle();
    send_raw(w);
  endtask

  task automatic drain();
    repeat (8) @(negedge clk);
    wait_idle();
    repeat (2) @(negedge clk);
    chk("txq_empty", txq.size(), 0);
    chk("aluq_empty", aluq.size(), 0);
  endtask

  // ALU responder: checks the issued operation and answers after a delay
  initial begin
    alu_exp_t e;
    bus.alu_done   = 1'b0;
    bus.alu_result = '0;
    forever begin
      @(negedge clk);
      if (alu_auto && bus.alu_start === 1'b1) begin
        if (aluq.size() == 0) begin
          chk("alu_unexpected_start", {31'd0, bus.alu_start}, 32'd0);
        end else begin
          e = aluq.pop_front();
          chk("alu_op", bus.alu_op, e.op);
          chk("alu_a", bus.alu_a, e.a);
          chk("alu_b", bus.alu_b, e.b);
          repeat (3) @(negedge clk);
          bus.alu_done   = 1'b1;
          bus.alu_result = e.r;
          @(negedge clk);
          bus.alu_done = 1'b0;
          if (e.bin) chk("done_to_load", {31'd0, bus.tx_load}, 32'd1);
        end
      end
    end
  end

  // tx scoreboard and alu_start counter
  initial begin
    logic [15:0] exp;
    forever begin
      @(negedge clk);
      if (bus.alu_start === 1'b1) start_cnt++;
      if (bus.tx_load === 1'b1) begin
        if (txq.size() == 0) begin
          chk("tx_unexpected", {31'd0, bus.tx_load}, 32'd0);
        end else begin
          exp = txq.pop_front();
          chk("tx_word", bus.tx_word, exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    bus.rx_valid = 1'b0;
    bus.rx_word  = '0;

    // Reset values
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_word", bus.tx_word, 16'h0000);
    chk("rst_tx_load", {31'd0, bus.tx_load}, 32'd0);
    chk("rst_alu_start", {31'd0, bus.alu_start}, 32'd0);
    chk("rst_alu_op", bus.alu_op, 2'd0);
    chk("rst_alu_a", bus.alu_a, 16'h0000);
    chk("rst_alu_b", bus.alu_b, 16'h0000);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    rst = 1'b1;
    txq.push_back(16'h0000);
    send(OP_LOAD_ACC);
    drain();

    // MUL
    push_alu(ALU_MUL, 16'h4148, 16'h404d, 16'h4220, 1'b1);
    txq.push_back(16'h4220);
    send(OP_MUL);
    send(16'h4148);
    send(16'h404d);
    chk("start_latency", {31'd0, bus.alu_start}, 32'd1);
    chk("mul_busy", {31'd0, bus.busy}, 32'd1);
    drain();

    // SUB binary with trailing dummy word
    push_alu(ALU_SUB, 16'h4237, 16'h441c, 16'hc411, 1'b1);
    txq.push_back(16'hc411);
    send(OP_SUB);
    send(16'h4237);
    send(16'h441c);
    send(END_WORD);
    drain();
    chk("sub_trailing_err", {31'd0, bus.err}, 32'd0);

    // SUM stream: 1+2+3+1 = 7
    s0 = start_cnt;
    push_alu(ALU_ADD, 16'h0000, 16'h3f80, 16'h3f80, 1'b0);
    push_alu(ALU_ADD, 16'h3f80, 16'h4000, 16'h4040, 1'b0);
    push_alu(ALU_ADD, 16'h4040, 16'h4040, 16'h40c0, 1'b0);
    push_alu(ALU_ADD, 16'h40c0, 16'h3f80, 16'h40e0, 1'b0);
    send(OP_SUM);
    send(16'h3f80); send(16'h4000); send(16'h4040); send(16'h3f80);
    send(END_WORD);
    drain();
    chk("sum_start_count", start_cnt - s0, 4);
    txq.push_back(16'h40e0);
    send(OP_LOAD_ACC);
    drain();

    // SUB stream: 0-1-2-3 = -6
    push_alu(ALU_SUB, 16'h0000, 16'h3f80, 16'hbf80, 1'b0);
    push_alu(ALU_SUB, 16'hbf80, 16'h4000, 16'hc040, 1'b0);
    push_alu(ALU_SUB, 16'hc040, 16'h4040, 16'hc0c0, 1'b0);
    send(OP_SUBS);
    send(16'h3f80); send(16'h4000); send(16'h4040);
    send(END_WORD);
    txq.push_back(16'hc0c0);
    send(OP_LOAD_ACC);
    drain();

    // SET_ACC then ZERO
    send(OP_SET_ACC);
    send(16'hbbbb);
    txq.push_back(16'hbbbb);
    send(OP_LOAD_ACC);
    drain();
    send(OP_ZERO);
    txq.push_back(16'h0000);
    send(OP_LOAD_ACC);
    drain();

    // Illegal opcode, then clear
    send(16'h0009);
    chk("illegal_err", {31'd0, bus.err}, 32'd1);
    send(OP_ZERO);
    chk("zero_clears_err", {31'd0, bus.err}, 32'd0);

    // Overrun during EXEC
    push_alu(ALU_ADD, 16'h1111, 16'h2222, 16'h3333, 1'b1);
    txq.push_back(16'h3333);
    send(OP_ADD);
    send(16'h1111);
    send(16'h2222);
    send_raw(16'h5555);
    chk("overrun_err", {31'd0, bus.err}, 32'd1);
    chk("overrun_dropped", bus.alu_b, 16'h2222);
    drain();
    send(OP_ZERO);
    chk("overrun_cleared", {31'd0, bus.err}, 32'd0);

    // Timeout: alu_done withheld; acc must survive
    send(OP_SET_ACC);
    send(16'h4321);
    alu_auto = 1'b0;
    send(OP_DIV);
    send(16'h1234);
    send(16'h5678);
    repeat (58) @(negedge clk);
    chk("timeout_still_busy", {31'd0, bus.busy}, 32'd1);
    chk("timeout_err_early", {31'd0, bus.err}, 32'd0);
    repeat (10) @(negedge clk);
    chk("timeout_idle", {31'd0, bus.busy}, 32'd0);
    chk("timeout_err", {31'd0, bus.err}, 32'd1);
    alu_auto = 1'b1;
    txq.push_back(16'h4321);
    send(OP_LOAD_ACC);
    drain();
    send(OP_ZERO);
    chk("timeout_err_cleared", {31'd0, bus.err}, 32'd0);

    // Reset mid-EXEC, then a late alu_done
    send(OP_SET_ACC);
    send(16'h5a5a);
    alu_auto = 1'b0;
    send(OP_MUL);
    send(16'h3f80);
    send(16'h4000);
    repeat (2) @(negedge clk);
    chk("midexec_busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("mr_busy", {31'd0, bus.busy}, 32'd0);
    chk("mr_err", {31'd0, bus.err}, 32'd0);
    chk("mr_tx_load", {31'd0, bus.tx_load}, 32'd0);
    chk("mr_tx_word", bus.tx_word, 16'h0000);
    chk("mr_alu_start", {31'd0, bus.alu_start}, 32'd0);
    chk("mr_alu_op", bus.alu_op, 2'd0);
    chk("mr_alu_a", bus.alu_a, 16'h0000);
    chk("mr_alu_b", bus.alu_b, 16'h0000);
    bus.alu_done   = 1'b1;
    bus.alu_result = 16'h7777;
    @(negedge clk);
    bus.alu_done = 1'b0;
    chk("late_done_no_load", {31'd0, bus.tx_load}, 32'd0);
    @(negedge clk);
    chk("late_done_no_load2", {31'd0, bus.tx_load}, 32'd0);
    alu_auto = 1'b1;
    txq.push_back(16'h0000);
    send(OP_LOAD_ACC);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
